// File: rtl/apb_fifo_slave.sv
// APB responder fronting a write FIFO drained by a valid/ready consumer.
// Optional build macro APB_FIFO_BACKPRESSURE_EN: stall full DATA writes instead of dropping them.
module apb_fifo_slave #(
    parameter int DEPTH       = 8,
    parameter int WAIT_STATES = 0,
    parameter int DATA_W      = 32
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [31:0]       PADDR,
    input  logic              PWRITE,
    input  logic              PENABLE,
    input  logic [31:0]       PWDATA,
    input  logic              PSEL,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              irq
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS      = 4'(WAIT_STATES);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_THRESH = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [AW:0]       count_reg, count_next;
    logic              ovf_reg, ovf_next;
    logic [7:0]        thresh_reg, thresh_next;
    logic [3:0]        cnt_reg;
    logic              irq_reg, irq_next;

    logic       access, ready_base, stall, done;
    logic       fifo_empty, fifo_full;
    logic       flush, pop, push_req, push, ovf_set, ovf_clr, thresh_wr;
    logic [1:0] addr;
    logic [DATA_W-1:0] head;
    logic       unused_ok;

    assign addr       = PADDR[3:2];
    assign access     = PSEL & PENABLE;
    assign ready_base = PRESET & access & (cnt_reg == WS);
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == DEPTH_C);
    assign head       = mem[rd_ptr_reg];

    // Flush is decoded from ready_base (CTRL never stalls) so pop/stall stay acyclic.
    assign flush = ready_base & PWRITE & (addr == A_CTRL) & PWDATA[0];
    assign pop   = out_valid & out_ready & ~flush;

`ifdef APB_FIFO_BACKPRESSURE_EN
    assign stall = access & PWRITE & (addr == A_DATA) & fifo_full & ~pop;
`else
    assign stall = 1'b0;
`endif

    assign done      = ready_base & ~stall;
    assign push_req  = done & PWRITE & (addr == A_DATA);
    assign push      = push_req & (~fifo_full | pop);
    assign ovf_set   = push_req & ~push;
    assign ovf_clr   = done & PWRITE & (addr == A_STATUS) & PWDATA[10];
    assign thresh_wr = done & PWRITE & (addr == A_THRESH);

    assign PREADY    = done;
    assign out_valid = PRESET & ~fifo_empty;
    assign out_data  = out_valid ? head : '0;
    assign irq       = irq_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
            if (push && !pop)
                count_next = count_reg + (AW+1)'(1);
            else if (pop && !push)
                count_next = count_reg - (AW+1)'(1);
        end
    end

    always_comb begin
        thresh_next = thresh_wr ? PWDATA[7:0] : thresh_reg;
        ovf_next    = ovf_reg;
        if (ovf_set)
            ovf_next = 1'b1;
        else if (ovf_clr)
            ovf_next = 1'b0;
        irq_next = (thresh_next != 8'd0) && (8'(count_next) >= thresh_next);
    end

    always_comb begin
        PRDATA = '0;
        if (PRESET && access && !PWRITE) begin
            case (addr)
                A_DATA:   PRDATA = fifo_empty ? 32'd0 : 32'(head);
                A_STATUS: PRDATA = {20'd0, irq_reg, ovf_reg, fifo_full, fifo_empty, 8'(count_reg)};
                A_CTRL:   PRDATA = '0;
                A_THRESH: PRDATA = {24'd0, thresh_reg};
                default:  PRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            thresh_reg <= '0;
            cnt_reg    <= '0;
            irq_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            ovf_reg    <= ovf_next;
            thresh_reg <= thresh_next;
            irq_reg    <= irq_next;
            if (!access)
                cnt_reg <= '0;
            else if (!done && cnt_reg != WS)
                cnt_reg <= cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (push)
            mem[wr_ptr_reg] <= PWDATA[DATA_W-1:0];
    end

    assign unused_ok = &{1'b0, PADDR[31:4], PADDR[1:0]};

endmodule
